// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module      : uart_pkg
// Description : Shared constants, register map, bit indices and FSM encodings
//               for the configurable UART (uart_cfg).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  // Register map (3-bit word address)
  localparam logic [2:0] ADDR_TX     = 3'd0;
  localparam logic [2:0] ADDR_RX     = 3'd1;
  localparam logic [2:0] ADDR_DIV_LO = 3'd2;
  localparam logic [2:0] ADDR_DIV_HI = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  // CTRL reset value: 8 data bits, no parity, 1 stop bit
  localparam logic [7:0] CTRL_RESET = 8'h03;

  // CTRL bit indices ([1:0] hold data bits minus 5)
  localparam int CTRL_PAR_EN   = 2;
  localparam int CTRL_PAR_ODD  = 3;
  localparam int CTRL_TWO_STOP = 4;
  localparam int CTRL_LOOPBACK = 5;
  localparam int CTRL_RX_IE    = 6;
  localparam int CTRL_TX_IE    = 7;

  // STATUS bit indices
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_FRAME    = 4;
  localparam int ST_PARITY   = 5;
  localparam int ST_OVERRUN  = 6;
  localparam int ST_TX_BUSY  = 7;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Mask selecting the active data bits for a CTRL[1:0] length code
  function automatic logic [7:0] data_mask(input logic [1:0] len_sel);
    logic [7:0] m;
    case (len_sel)
      2'd0:    m = 8'h1F;
      2'd1:    m = 8'h3F;
      2'd2:    m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Parity bit for a frame: XOR of the active data bits, inverted for odd
  function automatic logic frame_parity(input logic [7:0] data,
                                        input logic [1:0] len_sel,
                                        input logic       odd);
    return (^(data & data_mask(len_sel))) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
//------------------------------------------------------------------------------
// Module      : uart_fifo
// Description : Synchronous show-ahead FIFO. A push on a full FIFO is honoured
//               only when a pop happens in the same cycle; a pop on an empty
//               FIFO is ignored.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign data_out = mem[rd_ptr];

  // Storage array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_cfg.sv
//------------------------------------------------------------------------------
// Module      : uart_cfg
// Description : Configurable UART (5-8 data bits, optional parity, 1/2 stop
//               bits, 16-bit baud divider) with TX/RX FIFOs, 16x oversampled
//               receiver and a Wishbone-style register slave.
//               Optional feature macro: UART_LOOPBACK_EN (CTRL[5] routes TX
//               serial to RX internally and holds tx_bit high).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_cfg
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DIV_DEFAULT = 16'd78,
  parameter int          OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tx_bit,
  input  logic       rx_bit,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_data_in,
  output logic [7:0] wb_data_out,
  input  logic       wb_we,
  input  logic       wb_stb,
  output logic       wb_ack,
  output logic       irq
);

  // Tick index that closes a bit cell, and the start-bit re-check point
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  // ---------------------------------------------------------------- bus side
  logic        access, wr_en, rd_en, div_wr, status_clr;
  logic [15:0] div;
  logic [7:0]  ctrl;
  logic [7:0]  status;
  logic [7:0]  rd_data;
  logic        frame_err, parity_err, overrun;
  logic        fe_set, pe_set, ovr_set;

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_fifo_out;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_fifo_out;

  assign access     = wb_stb & ~wb_ack;
  assign wr_en      = access & wb_we;
  assign rd_en      = access & ~wb_we;
  assign div_wr     = wr_en & ((wb_addr == ADDR_DIV_LO) | (wb_addr == ADDR_DIV_HI));
  assign status_clr = rd_en & (wb_addr == ADDR_STATUS);
  assign tx_push    = wr_en & (wb_addr == ADDR_TX);
  assign rx_pop     = rd_en & (wb_addr == ADDR_RX) & ~rx_empty;

  // Writable configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div  <= DIV_DEFAULT;
      ctrl <= CTRL_RESET;
    end else if (wr_en) begin
      case (wb_addr)
        ADDR_DIV_LO: div[7:0]  <= wb_data_in;
        ADDR_DIV_HI: div[15:8] <= wb_data_in;
        ADDR_CTRL:   ctrl      <= wb_data_in;
        default:     ;
      endcase
    end
  end

  // Read-data multiplexer
  always_comb begin
    rd_data = 8'h00;
    case (wb_addr)
      ADDR_RX:     rd_data = rx_empty ? 8'h00 : rx_fifo_out;
      ADDR_DIV_LO: rd_data = div[7:0];
      ADDR_DIV_HI: rd_data = div[15:8];
      ADDR_CTRL:   rd_data = ctrl;
      ADDR_STATUS: rd_data = status;
      default:     rd_data = 8'h00;
    endcase
  end

  // Registered acknowledge and read data (data is zero outside a read ack)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ack      <= 1'b0;
      wb_data_out <= 8'h00;
    end else begin
      wb_ack      <= access;
      wb_data_out <= rd_en ? rd_data : 8'h00;
    end
  end

  // Sticky error flags; a set in the clearing cycle wins over the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= fe_set  | (frame_err  & ~status_clr);
      parity_err <= pe_set  | (parity_err & ~status_clr);
      overrun    <= ovr_set | (overrun    & ~status_clr);
    end
  end

  // ---------------------------------------------------------------- baud tick
  logic [15:0] baud_cnt;
  logic        tick;

  assign tick = (baud_cnt == div);

  // Free-running divider counter, restarted by any divider write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= 16'd0;
    end else if (div_wr || tick) begin
      baud_cnt <= 16'd0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------- FIFOs
  logic [7:0] rx_data;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_push),
    .data_in  (wb_data_in),
    .pop      (tx_pop),
    .data_out (tx_fifo_out),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .data_in  (rx_data),
    .pop      (rx_pop),
    .data_out (rx_fifo_out),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  // ---------------------------------------------------------------- TX FSM
  tx_state_t  tx_state, tx_state_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic [1:0] tx_len, tx_len_nxt;
  logic       tx_par_en, tx_par_en_nxt;
  logic       tx_par_bit, tx_par_bit_nxt;
  logic       tx_two_stop, tx_two_stop_nxt;
  logic       tx_stop2, tx_stop2_nxt;
  logic [3:0] tx_tick_cnt, tx_tick_cnt_nxt;
  logic [2:0] tx_bit_cnt, tx_bit_cnt_nxt;
  logic       tx_line, tx_line_nxt;
  logic       tx_busy;

  assign tx_busy = (tx_state != TX_IDLE);

  // TX state and datapath registers; idle line is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_shift    <= 8'h00;
      tx_len      <= 2'd3;
      tx_par_en   <= 1'b0;
      tx_par_bit  <= 1'b0;
      tx_two_stop <= 1'b0;
      tx_stop2    <= 1'b0;
      tx_tick_cnt <= 4'd0;
      tx_bit_cnt  <= 3'd0;
      tx_line     <= 1'b1;
    end else begin
      tx_state    <= tx_state_nxt;
      tx_shift    <= tx_shift_nxt;
      tx_len      <= tx_len_nxt;
      tx_par_en   <= tx_par_en_nxt;
      tx_par_bit  <= tx_par_bit_nxt;
      tx_two_stop <= tx_two_stop_nxt;
      tx_stop2    <= tx_stop2_nxt;
      tx_tick_cnt <= tx_tick_cnt_nxt;
      tx_bit_cnt  <= tx_bit_cnt_nxt;
      tx_line     <= tx_line_nxt;
    end
  end

  // TX next-state logic; frames start on a tick so every bit cell is exactly
  // OVERSAMPLE ticks long
  always_comb begin
    tx_state_nxt    = tx_state;
    tx_shift_nxt    = tx_shift;
    tx_len_nxt      = tx_len;
    tx_par_en_nxt   = tx_par_en;
    tx_par_bit_nxt  = tx_par_bit;
    tx_two_stop_nxt = tx_two_stop;
    tx_stop2_nxt    = tx_stop2;
    tx_tick_cnt_nxt = tx_tick_cnt;
    tx_bit_cnt_nxt  = tx_bit_cnt;
    tx_pop          = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tick && !tx_empty) begin
          tx_pop          = 1'b1;
          tx_shift_nxt    = tx_fifo_out;
          tx_len_nxt      = ctrl[1:0];
          tx_par_en_nxt   = ctrl[CTRL_PAR_EN];
          tx_par_bit_nxt  = frame_parity(tx_fifo_out, ctrl[1:0], ctrl[CTRL_PAR_ODD]);
          tx_two_stop_nxt = ctrl[CTRL_TWO_STOP];
          tx_tick_cnt_nxt = 4'd0;
          tx_state_nxt    = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          tx_tick_cnt_nxt = tx_tick_cnt + 4'd1;
          if (tx_tick_cnt == LAST_TICK) begin
            tx_bit_cnt_nxt = 3'd0;
            tx_state_nxt   = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_tick_cnt_nxt = tx_tick_cnt + 4'd1;
          if (tx_tick_cnt == LAST_TICK) begin
            // {1, len} is the index of the last data bit (4..7)
            if (tx_bit_cnt == {1'b1, tx_len}) begin
              tx_stop2_nxt = 1'b0;
              tx_state_nxt = tx_par_en ? TX_PARITY : TX_STOP;
            end else begin
              tx_bit_cnt_nxt = tx_bit_cnt + 3'd1;
              tx_shift_nxt   = {1'b0, tx_shift[7:1]};
            end
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          tx_tick_cnt_nxt = tx_tick_cnt + 4'd1;
          if (tx_tick_cnt == LAST_TICK) begin
            tx_state_nxt = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          tx_tick_cnt_nxt = tx_tick_cnt + 4'd1;
          if (tx_tick_cnt == LAST_TICK) begin
            if (tx_two_stop && !tx_stop2) begin
              tx_stop2_nxt = 1'b1;
            end else begin
              tx_state_nxt = TX_IDLE;
            end
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase

    // Serial level registered alongside the state it belongs to
    case (tx_state_nxt)
      TX_START:  tx_line_nxt = 1'b0;
      TX_DATA:   tx_line_nxt = tx_shift_nxt[0];
      TX_PARITY: tx_line_nxt = tx_par_bit_nxt;
      default:   tx_line_nxt = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX input
  logic rx_sync1, rx_sync2, rx_in;

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
    end else begin
      rx_sync1 <= rx_bit;
      rx_sync2 <= rx_sync1;
    end
  end

`ifdef UART_LOOPBACK_EN
  assign rx_in  = ctrl[CTRL_LOOPBACK] ? tx_line : rx_sync2;
  assign tx_bit = ctrl[CTRL_LOOPBACK] ? 1'b1 : tx_line;
`else
  assign rx_in  = rx_sync2;
  assign tx_bit = tx_line;
`endif

  // ---------------------------------------------------------------- RX FSM
  rx_state_t  rx_state, rx_state_nxt;
  logic [7:0] rx_data_nxt;
  logic [1:0] rx_len, rx_len_nxt;
  logic       rx_par_en, rx_par_en_nxt;
  logic       rx_par_odd, rx_par_odd_nxt;
  logic       rx_par_bad, rx_par_bad_nxt;
  logic [3:0] rx_tick_cnt, rx_tick_cnt_nxt;
  logic [2:0] rx_bit_cnt, rx_bit_cnt_nxt;

  // RX state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      rx_data     <= 8'h00;
      rx_len      <= 2'd3;
      rx_par_en   <= 1'b0;
      rx_par_odd  <= 1'b0;
      rx_par_bad  <= 1'b0;
      rx_tick_cnt <= 4'd0;
      rx_bit_cnt  <= 3'd0;
    end else begin
      rx_state    <= rx_state_nxt;
      rx_data     <= rx_data_nxt;
      rx_len      <= rx_len_nxt;
      rx_par_en   <= rx_par_en_nxt;
      rx_par_odd  <= rx_par_odd_nxt;
      rx_par_bad  <= rx_par_bad_nxt;
      rx_tick_cnt <= rx_tick_cnt_nxt;
      rx_bit_cnt  <= rx_bit_cnt_nxt;
    end
  end

  // RX next-state logic: detect low at a tick, confirm at mid start bit,
  // then sample once per bit cell
  always_comb begin
    rx_state_nxt    = rx_state;
    rx_data_nxt     = rx_data;
    rx_len_nxt      = rx_len;
    rx_par_en_nxt   = rx_par_en;
    rx_par_odd_nxt  = rx_par_odd;
    rx_par_bad_nxt  = rx_par_bad;
    rx_tick_cnt_nxt = rx_tick_cnt;
    rx_bit_cnt_nxt  = rx_bit_cnt;
    rx_push         = 1'b0;
    fe_set          = 1'b0;
    pe_set          = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (tick && !rx_in) begin
          rx_data_nxt     = 8'h00;
          rx_len_nxt      = ctrl[1:0];
          rx_par_en_nxt   = ctrl[CTRL_PAR_EN];
          rx_par_odd_nxt  = ctrl[CTRL_PAR_ODD];
          rx_par_bad_nxt  = 1'b0;
          rx_tick_cnt_nxt = 4'd0;
          rx_state_nxt    = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          rx_tick_cnt_nxt = rx_tick_cnt + 4'd1;
          if (rx_tick_cnt == MID_TICK) begin
            rx_tick_cnt_nxt = 4'd0;
            rx_bit_cnt_nxt  = 3'd0;
            rx_state_nxt    = rx_in ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_tick_cnt_nxt = rx_tick_cnt + 4'd1;
          if (rx_tick_cnt == LAST_TICK) begin
            rx_data_nxt[rx_bit_cnt] = rx_in;
            if (rx_bit_cnt == {1'b1, rx_len}) begin
              rx_state_nxt = rx_par_en ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_cnt_nxt = rx_bit_cnt + 3'd1;
            end
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          rx_tick_cnt_nxt = rx_tick_cnt + 4'd1;
          if (rx_tick_cnt == LAST_TICK) begin
            rx_par_bad_nxt = (rx_in != frame_parity(rx_data, rx_len, rx_par_odd));
            rx_state_nxt   = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_tick_cnt_nxt = rx_tick_cnt + 4'd1;
          if (rx_tick_cnt == LAST_TICK) begin
            rx_push      = 1'b1;
            fe_set       = ~rx_in;
            pe_set       = rx_par_bad;
            rx_state_nxt = RX_IDLE;
          end
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // A push into a full FIFO is lost unless the bus pops in the same cycle
  assign ovr_set = rx_push & rx_full & ~rx_pop;

  // ---------------------------------------------------------------- status
  assign status = {tx_busy, overrun, parity_err, frame_err,
                   rx_empty, rx_full, tx_empty, tx_full};

  assign irq = (~rx_empty & ctrl[CTRL_RX_IE]) | (tx_empty & ctrl[CTRL_TX_IE]);

endmodule

`default_nettype wire

// File: tb/tb_uart_cfg.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_cfg
// Description : Directed self-checking bench for uart_cfg. Loopback checks are
//               included when UART_LOOPBACK_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_cfg;

  localparam int DEPTH    = 16;
  localparam int BIT_CLKS = 64;   // divider 3 -> 4 clk per tick, 16 ticks per bit

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_bit;
  logic       rx_bit;
  logic [2:0] wb_addr;
  logic [7:0] wb_data_in;
  logic [7:0] wb_data_out;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack;
  logic       irq;

  int checks = 0;
  int errors = 0;

  uart_cfg #(.FIFO_DEPTH(DEPTH), .DIV_DEFAULT(16'd78), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_bit      (tx_bit),
    .rx_bit      (rx_bit),
    .wb_addr     (wb_addr),
    .wb_data_in  (wb_data_in),
    .wb_data_out (wb_data_out),
    .wb_we       (wb_we),
    .wb_stb      (wb_stb),
    .wb_ack      (wb_ack),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One bus access; waits (bounded) for the acknowledge
  task automatic bus_access(input logic [2:0] a, input logic we, input logic [7:0] d,
                            output logic [7:0] q);
    int n;
    @(negedge clk);
    wb_addr = a; wb_we = we; wb_data_in = d; wb_stb = 1'b1;
    n = 0;
    q = 8'h00;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb_ack && n < 8);
    if (!wb_ack) check_value("bus_ack_timeout", 16'(n), 16'd1);
    q = wb_data_out;
    wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    bus_access(a, 1'b1, d, dummy);
  endtask

  task automatic bus_read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] q;
    bus_access(a, 1'b0, 8'h00, q);
    check_value(tag, 16'(q), 16'(exp));
  endtask

  // Drive one serial frame onto rx_bit followed by two idle bit times
  task automatic send_rx(input logic [7:0] data, input int nbits, input bit par_en,
                         input logic par, input logic stop);
    rx_bit = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_bit = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (par_en) begin
      rx_bit = par;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_bit = stop;
    repeat (BIT_CLKS) @(negedge clk);
    rx_bit = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    logic [8:0] tx_pattern;
    int         low_cnt;
    int         acks;

    reset = 1'b1; rx_bit = 1'b1;
    wb_addr = 3'd0; wb_data_in = 8'h00; wb_we = 1'b0; wb_stb = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_tx_bit", 16'(tx_bit), 16'd1);
    check_value("rst_ack", 16'(wb_ack), 16'd0);
    check_value("rst_rdata", 16'(wb_data_out), 16'd0);
    check_value("rst_irq", 16'(irq), 16'd0);
    reset = 1'b0;

    // Reset register values
    bus_read_check("rst_status", 3'd5, 8'h0A);
    bus_read_check("rst_ctrl", 3'd4, 8'h03);
    bus_read_check("rst_div_lo", 3'd2, 8'd78);
    bus_read_check("rst_div_hi", 3'd3, 8'd0);
    bus_read_check("reg6_zero", 3'd6, 8'h00);
    bus_read_check("rx_empty_read", 3'd1, 8'h00);

    // Held strobe: accesses at cycles 1 and 3 of a 4-cycle hold
    @(negedge clk);
    wb_addr = 3'd4; wb_we = 1'b0; wb_stb = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb_ack) acks++;
    end
    wb_stb = 1'b0;
    @(posedge clk);
    check_value("held_stb_acks", 16'(acks), 16'd2);

    // TX 0x55 8N1 at divider 3
    bus_write(3'd2, 8'd3);
    bus_write(3'd0, 8'h55);
    low_cnt = 0;
    for (int i = 0; i < 200 && tx_bit == 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 200 && tx_bit == 1'b0; i++) begin
      low_cnt++;
      @(negedge clk);
    end
    check_value("tx_start_len", 16'(low_cnt), 16'd64);
    tx_pattern = {1'b1, 8'h55};
    repeat (32) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      check_value($sformatf("tx_cell%0d", k), 16'(tx_bit), 16'(tx_pattern[k]));
      repeat (64) @(negedge clk);
    end
    bus_read_check("tx_done_status", 3'd5, 8'h0A);

    // RX 0x41, 7 data bits, odd parity (parity bit 1)
    bus_write(3'd4, 8'h0E);
    send_rx(8'h41, 7, 1'b1, 1'b1, 1'b1);
    bus_read_check("rx_7o1_data", 3'd1, 8'h41);
    bus_read_check("rx_7o1_status", 3'd5, 8'h0A);

    // Same frame with a wrong parity bit
    send_rx(8'h41, 7, 1'b1, 1'b0, 1'b1);
    bus_read_check("rx_pe_status", 3'd5, 8'h22);
    bus_read_check("rx_pe_data", 3'd1, 8'h41);
    bus_read_check("rx_pe_cleared", 3'd5, 8'h0A);

    // 8N1 frame with a low stop bit
    bus_write(3'd4, 8'h03);
    send_rx(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    bus_read_check("rx_fe_status", 3'd5, 8'h12);
    bus_read_check("rx_fe_cleared", 3'd5, 8'h02);
    bus_read_check("rx_fe_data", 3'd1, 8'h3C);

    // Overrun: DEPTH+1 frames without reading
    for (int i = 0; i <= DEPTH; i++) send_rx(8'(8'h10 + i), 8, 1'b0, 1'b0, 1'b1);
    bus_read_check("ovr_status", 3'd5, 8'h46);
    for (int i = 0; i < DEPTH; i++) bus_read_check($sformatf("ovr_data%0d", i), 3'd1, 8'(8'h10 + i));
    bus_read_check("ovr_drained", 3'd5, 8'h0A);

    // Interrupt enables
    bus_write(3'd4, 8'h80);
    @(negedge clk);
    check_value("irq_tx_empty", 16'(irq), 16'd1);
    bus_write(3'd4, 8'h40);
    @(negedge clk);
    check_value("irq_rx_empty", 16'(irq), 16'd0);

`ifdef UART_LOOPBACK_EN
    begin
      int highs;
      bus_write(3'd4, 8'h23);
      bus_write(3'd0, 8'hA5);
      highs = 0;
      for (int i = 0; i < 900; i++) begin
        @(negedge clk);
        if (tx_bit) highs++;
      end
      check_value("lb_tx_idle", 16'(highs), 16'd900);
      bus_read_check("lb_rx_data", 3'd1, 8'hA5);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
